// File: rtl/mult_sequencer.sv
// Sequential 2*SIZE x 2*SIZE unsigned multiplier reusing one SIZE x SIZE tree_multiplier over four steps.
// Optional MULT_SEQ_ZERO_SKIP_EN: zero operands bypass MUL and present product=0 one cycle after accept.

module tree_multiplier #(
   parameter int SIZE = 4
) (
   input  logic [SIZE-1:0]   i_x,
   input  logic [SIZE-1:0]   i_y,
   output logic [2*SIZE-1:0] o_p
);
   always_comb begin
      o_p = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (i_y[i]) begin
            o_p = o_p + ({{SIZE{1'b0}}, i_x} << i);
         end
      end
   end
endmodule

module mult_sequencer #(
   parameter int SIZE = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*SIZE-1:0]   a,
   input  logic [2*SIZE-1:0]   b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*SIZE-1:0]   product,
   output logic                busy
);
   localparam int W = 2 * SIZE;
   localparam int P = 4 * SIZE;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_step;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic [P-1:0]     r_acc;
   logic [P-1:0]     r_product;
   logic             r_out_valid;
   logic             w_zero;
   logic [SIZE-1:0]  w_mul_x;
   logic [SIZE-1:0]  w_mul_y;
   logic [W-1:0]     w_pp;
   logic [P-1:0]     w_pp_ext;
   logic [P-1:0]     w_pp_sh;
   logic [P-1:0]     w_acc_next;

`ifdef MULT_SEQ_ZERO_SKIP_EN
   assign w_zero = (a == '0) || (b == '0);
`else
   assign w_zero = 1'b0;
`endif

   // step[1] selects the high half of a, step[0] the high half of b
   assign w_mul_x = r_step[1] ? r_a[W-1:SIZE] : r_a[SIZE-1:0];
   assign w_mul_y = r_step[0] ? r_b[W-1:SIZE] : r_b[SIZE-1:0];

   tree_multiplier #(.SIZE(SIZE)) u_tree (
      .i_x (w_mul_x),
      .i_y (w_mul_y),
      .o_p (w_pp)
   );

   assign w_pp_ext = {{(P-W){1'b0}}, w_pp};

   always_comb begin
      w_pp_sh = w_pp_ext;
      case (r_step)
         2'd0:    w_pp_sh = w_pp_ext;
         2'd3:    w_pp_sh = w_pp_ext << W;
         default: w_pp_sh = w_pp_ext << SIZE;
      endcase
   end

   assign w_acc_next = r_acc + w_pp_sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      busy     = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_next = w_zero ? DONE : MUL;
            end
         end
         MUL: begin
            if (r_step == 2'd3) begin
               w_next = DONE;
            end
         end
         DONE: begin
            if (r_out_valid && out_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_product   <= '0;
         r_step      <= 2'd0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_acc     <= '0;
                  r_product <= '0;
                  r_step    <= 2'd0;
               end
            end
            MUL: begin
               r_acc  <= w_acc_next;
               r_step <= r_step + 2'd1;
               if (r_step == 2'd3) begin
                  r_product   <= w_acc_next;
                  r_out_valid <= 1'b1;
               end
            end
            DONE: begin
               // Zero-skip enters DONE with out_valid still low; raise it one cycle later
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: r_out_valid <= 1'b0;
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign product   = r_product;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer (SIZE=4) with immediate-assertion checks.
module tb_mult_sequencer;
   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   int n_cmp;
   int n_bad;

   mult_sequencer #(.SIZE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a/b, scramble the inputs, wait for out_valid and check latency/product.
   // Leaves the DUT in DONE with out_valid high.
   task automatic start_and_wait(input string tag, input logic [7:0] va, input logic [7:0] vb,
                                 input logic [15:0] exp_p, input int exp_lat);
      int lat;
      a = va;
      b = vb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 8'h55;
      b = 8'h55;
      check({tag, " in_ready after accept"}, {31'd0, in_ready}, 32'd0);
      check({tag, " busy after accept"}, {31'd0, busy}, 32'd1);
      check({tag, " product cleared on accept"}, {16'd0, product}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " product"}, {16'd0, product}, {16'd0, exp_p});
      check({tag, " busy in DONE"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic finish_op(input string tag);
      out_ready = 1'b1;
      tick();
      check({tag, " in_ready after handshake"}, {31'd0, in_ready}, 32'd1);
      check({tag, " out_valid after handshake"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int zlat;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = 8'h00;
      b = 8'h00;
`ifdef MULT_SEQ_ZERO_SKIP_EN
      zlat = 1;
`else
      zlat = 4;
`endif

      #12;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset product", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("in_ready after reset", {31'd0, in_ready}, 32'd1);

      start_and_wait("12x34", 8'h12, 8'h34, 16'h03A8, 4);
      finish_op("12x34");
      start_and_wait("FFxFF", 8'hFF, 8'hFF, 16'hFE01, 4);
      finish_op("FFxFF");
      start_and_wait("01xFF", 8'h01, 8'hFF, 16'h00FF, 4);
      finish_op("01xFF");
      start_and_wait("00xAB", 8'h00, 8'hAB, 16'h0000, zlat);
      finish_op("00xAB");

      // Stall with out_ready low while new operands are offered
      out_ready = 1'b0;
      start_and_wait("0FxF0", 8'h0F, 8'hF0, 16'h0E10, 4);
      for (int i = 0; i < 3; i++) begin
         a = 8'h11;
         b = 8'h22;
         in_valid = 1'b1;
         tick();
         check("stall product", {16'd0, product}, 32'h0E10);
         check("stall out_valid", {31'd0, out_valid}, 32'd1);
         check("stall in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      finish_op("0FxF0");
      tick();
      check("no stray op busy", {31'd0, busy}, 32'd0);

      start_and_wait("03x05 held", 8'h03, 8'h05, 16'h000F, 4);
      finish_op("03x05");

      // Reset during step 2
      a = 8'hAA;
      b = 8'h55;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
      check("mid reset busy", {31'd0, busy}, 32'd0);
      check("mid reset product", {16'd0, product}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
      start_and_wait("0Ax0B", 8'h0A, 8'h0B, 16'h006E, 4);
      finish_op("0Ax0B");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
